// File: rtl/ailn_out_packer.sv
// ailn_out_packer: packs serial signed bytes into DATA_WIDTH-bit words with a fill/output register pair
module ailn_out_packer #(
    parameter int DATA_WIDTH = 192,
    localparam int COUNT = DATA_WIDTH / 8,
    localparam int CNT_WIDTH = $clog2(COUNT)
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_clear,
    input  logic                  i_valid,
    input  logic [7:0]            i_data,
    output logic                  o_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [CNT_WIDTH:0]    o_count,
    output logic                  o_overflow
);
    typedef enum logic {FILL, HOLD} state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] fill;
    logic [DATA_WIDTH-1:0] fill_ins;
    logic                  accept;
    logic                  last;
    logic                  slot_free;

    // o_ready comes straight from the state register, so it never sees i_valid or i_ready
    assign o_ready   = state == FILL;
    assign accept    = i_valid && o_ready;
    assign last      = o_count == (CNT_WIDTH + 1)'(COUNT - 1);
    assign slot_free = !o_valid || i_ready;

    // Fill register with the incoming byte dropped into slot o_count (first byte lands on top)
    always_comb begin
        fill_ins = fill;
        for (int k = 0; k < COUNT; k++)
            if (int'(o_count) == k) fill_ins[DATA_WIDTH-1-8*k -: 8] = i_data;
    end

    // Fill FSM, output register and sticky overflow; clear overrides any same-cycle byte or handshake
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state      <= FILL;
            fill       <= '0;
            o_count    <= '0;
            o_data     <= '0;
            o_valid    <= 1'b0;
            o_overflow <= 1'b0;
        end else if (i_clear) begin
            state      <= FILL;
            fill       <= '0;
            o_count    <= '0;
            o_data     <= '0;
            o_valid    <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            if (i_valid && !o_ready) o_overflow <= 1'b1;
            if (state == HOLD) begin
                if (slot_free) begin
                    o_data  <= fill;
                    o_valid <= 1'b1;
                    fill    <= '0;
                    o_count <= '0;
                    state   <= FILL;
                end
            end else if (accept && last && slot_free) begin
                o_data  <= fill_ins;
                o_valid <= 1'b1;
                fill    <= '0;
                o_count <= '0;
            end else begin
                if (accept) begin
                    fill    <= fill_ins;
                    o_count <= o_count + 1'b1;
                    if (last) state <= HOLD;
                end
                if (o_valid && i_ready) o_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ailn_out_packer.sv
// tb_ailn_out_packer: directed self-checking bench for ailn_out_packer
module tb_ailn_out_packer;
    logic         clk = 1'b0;
    logic         rstn;
    logic         clear;
    logic         in_valid;
    logic [7:0]   in_data;
    logic         out_ready;
    logic [191:0] out_data;
    logic         out_valid;
    logic         down_ready;
    logic [5:0]   count;
    logic         overflow;
    int           n_assert = 0;
    int           n_fail = 0;

    ailn_out_packer #(.DATA_WIDTH(192)) dut (
        .i_clk(clk), .i_rstn(rstn), .i_clear(clear), .i_valid(in_valid), .i_data(in_data),
        .o_ready(out_ready), .o_data(out_data), .o_valid(out_valid), .i_ready(down_ready),
        .o_count(count), .o_overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = 8'h00; down_ready = 1'b1;
        cyc(); cyc();
        n_assert++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", out_valid); end
        n_assert++; if (out_data !== 192'h0) begin n_fail++; $display("FAIL reset_data got %h want 0", out_data); end
        n_assert++; if (count !== 6'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
        n_assert++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %b want 0", overflow); end
        n_assert++; if (out_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", out_ready); end
        rstn = 1'b1;
        cyc();
    endtask

    task automatic test_single_word();
        logic [191:0] exp;
        for (int k = 0; k < 24; k++) exp[191-8*k -: 8] = 8'(k + 1);
        down_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            in_valid = 1'b1; in_data = 8'(i + 1);
            cyc();
            n_assert++; if (out_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready byte %0d got %b want 1", i, out_ready); end
            n_assert++; if (out_valid !== (i == 23)) begin n_fail++; $display("FAIL single_valid byte %0d got %b want %b", i, out_valid, i == 23); end
            n_assert++; if (count !== ((i == 23) ? 6'd0 : 6'(i + 1))) begin n_fail++; $display("FAIL single_count byte %0d got %0d", i, count); end
        end
        n_assert++; if (out_data[191:184] !== 8'h01) begin n_fail++; $display("FAIL single_top got %h want 01", out_data[191:184]); end
        n_assert++; if (out_data[7:0] !== 8'h18) begin n_fail++; $display("FAIL single_bottom got %h want 18", out_data[7:0]); end
        n_assert++; if (out_data !== exp) begin n_fail++; $display("FAIL single_word got %h want %h", out_data, exp); end
        in_valid = 1'b0;
        cyc();
        n_assert++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_pulse got %b want 0", out_valid); end
        n_assert++; if (out_data !== exp) begin n_fail++; $display("FAIL single_keep got %h want %h", out_data, exp); end
    endtask

    task automatic test_back_to_back();
        logic [7:0]   v [48];
        logic [191:0] w1, w2;
        for (int i = 0; i < 48; i++) v[i] = 8'(i + 16);
        v[5] = 8'h80; v[30] = 8'hFF; v[47] = 8'h80;
        for (int k = 0; k < 24; k++) begin
            w1[191-8*k -: 8] = v[k];
            w2[191-8*k -: 8] = v[k+24];
        end
        down_ready = 1'b1;
        for (int i = 0; i < 48; i++) begin
            in_valid = 1'b1; in_data = v[i];
            cyc();
            n_assert++; if (out_valid !== (i == 23 || i == 47)) begin n_fail++; $display("FAIL b2b_valid byte %0d got %b", i, out_valid); end
            n_assert++; if (out_ready !== 1'b1 || overflow !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_ovf byte %0d got %b/%b want 1/0", i, out_ready, overflow); end
            if (i == 23) begin
                n_assert++; if (out_data !== w1) begin n_fail++; $display("FAIL b2b_word1 got %h want %h", out_data, w1); end
            end
            if (i == 47) begin
                n_assert++; if (out_data !== w2) begin n_fail++; $display("FAIL b2b_word2 got %h want %h", out_data, w2); end
            end
        end
        in_valid = 1'b0;
        cyc();
        n_assert++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got %b want 0", out_valid); end
    endtask

    task automatic test_backpressure();
        logic [191:0] w1, w2;
        for (int k = 0; k < 24; k++) begin
            w1[191-8*k -: 8] = 8'(k + 100);
            w2[191-8*k -: 8] = 8'(k + 124);
        end
        down_ready = 1'b0;
        for (int i = 0; i < 48; i++) begin
            in_valid = 1'b1; in_data = 8'(i + 100);
            cyc();
            if (i >= 23) begin
                n_assert++; if (out_valid !== 1'b1 || out_data !== w1) begin n_fail++; $display("FAIL bp_hold byte %0d got %b %h want 1 %h", i, out_valid, out_data, w1); end
            end
            if (i >= 24) begin
                n_assert++; if (count !== 6'(i - 23)) begin n_fail++; $display("FAIL bp_count byte %0d got %0d want %0d", i, count, i - 23); end
                n_assert++; if (out_ready !== (i != 47)) begin n_fail++; $display("FAIL bp_ready byte %0d got %b want %b", i, out_ready, i != 47); end
            end
        end
        in_data = 8'hEE;
        cyc();
        n_assert++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL bp_overflow got %b want 1", overflow); end
        n_assert++; if (count !== 6'd24 || out_data !== w1) begin n_fail++; $display("FAIL bp_drop got %0d %h want 24 %h", count, out_data, w1); end
        in_valid = 1'b0; down_ready = 1'b1;
        cyc();
        down_ready = 1'b0;
        n_assert++; if (out_valid !== 1'b1 || out_data !== w2) begin n_fail++; $display("FAIL bp_release got %b %h want 1 %h", out_valid, out_data, w2); end
        n_assert++; if (out_ready !== 1'b1 || count !== 6'd0) begin n_fail++; $display("FAIL bp_release_fill got %b %0d want 1 0", out_ready, count); end
        cyc();
        n_assert++; if (out_valid !== 1'b1 || out_data !== w2) begin n_fail++; $display("FAIL bp_stall got %b %h want 1 %h", out_valid, out_data, w2); end
        down_ready = 1'b1;
        cyc();
        n_assert++; if (out_valid !== 1'b0 || overflow !== 1'b1) begin n_fail++; $display("FAIL bp_done got %b/%b want 0/1", out_valid, overflow); end
    endtask

    task automatic test_clear();
        logic [191:0] exp;
        for (int k = 0; k < 24; k++) exp[191-8*k -: 8] = 8'(k + 8'h30);
        down_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_data = 8'(i + 8'hC0);
            cyc();
        end
        n_assert++; if (count !== 6'd10) begin n_fail++; $display("FAIL clr_pre_count got %0d want 10", count); end
        clear = 1'b1; in_data = 8'hEE;
        cyc();
        clear = 1'b0; in_valid = 1'b0;
        n_assert++; if (count !== 6'd0 || overflow !== 1'b0) begin n_fail++; $display("FAIL clr_state got %0d/%b want 0/0", count, overflow); end
        n_assert++; if (out_valid !== 1'b0 || out_data !== 192'h0 || out_ready !== 1'b1) begin n_fail++; $display("FAIL clr_out got %b %h %b", out_valid, out_data, out_ready); end
        for (int i = 0; i < 24; i++) begin
            in_valid = 1'b1; in_data = 8'(i + 8'h30);
            cyc();
        end
        in_valid = 1'b0;
        n_assert++; if (out_valid !== 1'b1 || out_data !== exp) begin n_fail++; $display("FAIL clr_word got %b %h want 1 %h", out_valid, out_data, exp); end
        cyc();
    endtask

    task automatic test_gaps();
        logic [191:0] exp;
        for (int k = 0; k < 24; k++) exp[191-8*k -: 8] = 8'(k + 8'hA0);
        down_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            in_valid = 1'b1; in_data = 8'(i + 8'hA0);
            cyc();
            in_valid = 1'b0;
            if (i < 23) begin
                n_assert++; if (count !== 6'(i + 1) || out_valid !== 1'b0) begin n_fail++; $display("FAIL gap_count byte %0d got %0d/%b want %0d/0", i, count, out_valid, i + 1); end
                cyc(); cyc();
                n_assert++; if (count !== 6'(i + 1)) begin n_fail++; $display("FAIL gap_hold byte %0d got %0d want %0d", i, count, i + 1); end
            end
        end
        n_assert++; if (out_valid !== 1'b1 || out_data !== exp || count !== 6'd0) begin n_fail++; $display("FAIL gap_word got %b %h %0d want 1 %h 0", out_valid, out_data, count, exp); end
        cyc();
        n_assert++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL gap_pulse got %b want 0", out_valid); end
    endtask

    task automatic test_async_reset();
        logic [191:0] exp;
        for (int k = 0; k < 24; k++) exp[191-8*k -: 8] = 8'(k + 8'h50);
        down_ready = 1'b0;
        for (int i = 0; i < 48; i++) begin
            in_valid = 1'b1; in_data = 8'(i + 8'h60);
            cyc();
        end
        in_valid = 1'b0;
        n_assert++; if (out_ready !== 1'b0 || out_valid !== 1'b1) begin n_fail++; $display("FAIL ar_hold got %b/%b want 0/1", out_ready, out_valid); end
        #2 rstn = 1'b0;
        #1;
        n_assert++; if (out_valid !== 1'b0 || out_data !== 192'h0 || count !== 6'd0) begin n_fail++; $display("FAIL ar_clear got %b %h %0d", out_valid, out_data, count); end
        n_assert++; if (out_ready !== 1'b1 || overflow !== 1'b0) begin n_fail++; $display("FAIL ar_ready got %b/%b want 1/0", out_ready, overflow); end
        cyc();
        rstn = 1'b1; down_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            in_valid = 1'b1; in_data = 8'(i + 8'h50);
            cyc();
        end
        in_valid = 1'b0;
        n_assert++; if (out_valid !== 1'b1 || out_data !== exp) begin n_fail++; $display("FAIL ar_word got %b %h want 1 %h", out_valid, out_data, exp); end
        cyc();
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_backpressure();
        test_clear();
        test_gaps();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/ailn_out_packer.md
# ailn_out_packer

Output-side packer for the AILayerNorm datapath. It collects the serial signed 8-bit normalized results, one byte per valid strobe, and rebuilds them into one DATA_WIDTH-bit word. Byte order matches the input vector: the first result goes to the top byte. Packed words leave on a valid/ready interface. A fill register and an output register are chained, so a full word drains while the next one fills, giving zero-bubble throughput.

## Interface
- DATA_WIDTH, 192: packed word width. Must be a multiple of 8, with COUNT = DATA_WIDTH/8 ≥ 2.
- CNT_WIDTH, derived: $clog2(COUNT). Not overridable.
- i_clk, in, 1: clock.
- i_rstn, in, 1: reset, asynchronous, active-low.
- i_clear, in, 1: synchronous flush. Highest priority after reset.
- i_valid, in, 1: byte strobe from the normalization stage.
- i_data, in, 8: signed normalized byte. Packed raw, with no sign extension.
- o_ready, out, 1: packer can accept a byte this cycle.
- o_data, out, DATA_WIDTH: packed word. Byte k sits at [DATA_WIDTH-1-8k -: 8].
- o_valid, out, 1: o_data holds a complete word.
- i_ready, in, 1: downstream accepts o_data.
- o_count, out, CNT_WIDTH+1: bytes currently in the fill register, range 0..COUNT.
- o_overflow, out, 1: sticky flag. Set when a byte arrives while o_ready=0.

## Operation
- Fill FSM has two states:
  - FILL: o_ready=1.
  - HOLD: the fill register is complete and waits for the output slot. o_ready=0.
- Accept condition: a byte is accepted when i_valid && o_ready. Byte k (k = o_count) is written to fill[DATA_WIDTH-1-8k -: 8] and o_count increments.
- Last byte (k = COUNT-1) accepted, slot free (!o_valid || i_ready in the same cycle):
  - The output register loads the fill contents including the current byte.
  - o_valid becomes 1.
  - The fill register zeroes and o_count goes to 0.
  - State stays FILL.
- Last byte accepted, slot busy:
  - The fill register captures the byte and o_count becomes COUNT.
  - State goes to HOLD.
- In HOLD, when !o_valid || i_ready:
  - The fill register moves to the output register and o_valid becomes 1.
  - The fill register zeroes and o_count goes to 0.
  - State returns to FILL.
- Output handshake:
  - o_valid && i_ready with no reload in the same cycle: o_valid goes to 0 and o_data keeps its last value.
  - o_valid && !i_ready: o_data and o_valid hold stable.
- Overflow: i_valid && !o_ready drops the byte, sets o_overflow, and leaves o_count unchanged. o_overflow is cleared only by reset or i_clear.
- i_clear clears all of the following and overrides any same-cycle byte or handshake (a byte presented in that cycle is discarded):
  - o_count = 0.
  - Fill register = 0.
  - o_valid = 0 and o_data = 0.
  - o_overflow = 0.
  - State = FILL.

## Timing
- Reset values: o_valid 0, o_data 0, o_count 0, o_overflow 0, o_ready 1 (state FILL). Reset takes effect asynchronously, mid-word or mid-HOLD, with no partial word retained.
- Latency: the last byte accepted at edge t gives o_valid=1 and a complete o_data in the cycle after edge t.
- Throughput: one byte per cycle sustained when i_ready is held at 1. o_ready never drops in that case.
- Backpressure: with i_ready=0 and one word pending, after a further COUNT bytes o_ready falls in the cycle after the last byte.
- Release from HOLD: the cycle i_ready=1 is seen gives the new word on o_valid next cycle, and o_ready=1 next cycle. The first new byte is accepted one cycle after the release.
- o_ready depends only on the state register, with no combinational path from i_valid or i_ready.
- o_count updates at the accept edge, is visible the cycle after, and reads COUNT only in HOLD.
- Gaps in i_valid are allowed anywhere, and a partial word is held indefinitely.

## Test plan
- Reset, then 24 consecutive bytes 0x01..0x18 with i_ready=1:
  - o_valid pulses 1 cycle, one cycle after byte 24.
  - o_data[191:184]=0x01, o_data[7:0]=0x18.
  - o_ready stays 1 throughout.
- 48 back-to-back bytes including 0x80 and 0xFF, with i_ready=1:
  - Two words, o_valid on the cycles after bytes 24 and 48.
  - 0x80 and 0xFF land unmodified.
  - o_overflow stays 0.
- i_ready=0 and 48 bytes:
  - Word 1 held stable. After byte 48, o_ready=0 and o_count=24.
  - 49th byte: dropped, o_overflow=1.
  - Pulse i_ready=1 for one cycle: word 2 on o_data next cycle, o_ready=1, o_count=0.
- i_valid every 3rd cycle, 24 bytes 0xA0..0xB7, i_ready=1:
  - o_count increments 1..23 across the gaps.
  - Single word with o_data[191:184]=0xA0.
- 10 bytes, then i_clear together with an i_valid byte:
  - o_count=0 and o_overflow=0. The same-cycle byte is discarded.
  - The next 24 bytes 0x30..0x47 form a clean word starting 0x30.
- Assert i_rstn=0 asynchronously during HOLD with o_valid=1:
  - All outputs go to reset values immediately and o_ready=1.
  - The next 24 bytes pack correctly.
